// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM state encoding and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU.
// Handshake: a request is taken on a rising edge with start=1 and ready=1; done pulses for one
// cycle when Result/ALUFlags change; start while ready=0 is ignored and must be held by the requester.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;

  modport master (output start, ALUControl, a, b, input ready, done, Result, ALUFlags);
  modport slave  (input start, ALUControl, a, b, output ready, done, Result, ALUFlags);
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_last,
  output logic [WIDTH-1:0] o_product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_next;

  // Only the low WIDTH bits of the product are kept, so the accumulator never needs to be wider.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product  = w_acc_next;
  assign o_busy     = (r_cnt != '0);
  assign o_last     = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (o_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle ADD/SUB/logic ops with registered results and flags,
// plus an optional iterative MUL that holds ready low for WIDTH cycles.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_mc_if.slave    bus,
  output alu_state_e o_dbg_state
);
  alu_state_e       r_state;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic             w_accept;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;
  logic             w_mul_busy;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_product;

  assign w_accept = bus.start && r_ready;
  assign w_is_mul = (bus.ALUControl == OP_MUL) && (MUL_EN != 0);

  // SUB reuses the adder as a + ~b + 1; opcode bit 0 selects the inversion and the carry-in.
  assign w_b_op = bus.ALUControl[0] ? ~bus.b : bus.b;
  assign w_sum  = {1'b0, bus.a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, bus.ALUControl[0]};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.ALUControl)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = ~(bus.ALUControl[0] ^ bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) &
                (w_sum[WIDTH-1] ^ bus.a[WIDTH-1]);
      end
      OP_AND:  w_res = bus.a & bus.b;
      OP_ORR:  w_res = bus.a | bus.b;
      OP_EOR:  w_res = bus.a ^ bus.b;
      default: w_res = '0;
    endcase
  end

  // Reserved opcodes leave w_res at zero, which yields the required 4'b0100 flags.
  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end

  if (MUL_EN != 0) begin : g_mul
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_accept && w_is_mul),
      .i_a       (bus.a),
      .i_b       (bus.b),
      .o_busy    (w_mul_busy),
      .o_last    (w_mul_last),
      .o_product (w_mul_product)
    );
  end else begin : g_no_mul
    assign w_mul_busy    = 1'b0;
    assign w_mul_last    = 1'b0;
    assign w_mul_product = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state <= MULT;
            r_ready <= 1'b0;
          end else if (w_accept) begin
            r_result <= w_res;
            r_flags  <= w_flags;
            r_done   <= 1'b1;
          end
        end
        MULT: begin
          if (w_mul_last) begin
            r_result        <= w_mul_product;
            r_flags         <= '0;
            r_flags[FLAG_N] <= w_mul_product[WIDTH-1];
            r_flags[FLAG_Z] <= (w_mul_product == '0);
            r_done          <= 1'b1;
            r_ready         <= 1'b1;
            r_state         <= IDLE;
          end else if (!w_mul_busy) begin
            // Multiplier idle without a final step: recover to IDLE rather than hang.
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.Result   = r_result;
  assign bus.ALUFlags = r_flags;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32, MUL_EN=1): directed corner cases plus randomized traffic
// checked against an arithmetic reference model through an expected-value queue.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       reset;
  alu_state_e dbg_state;
  int         total;
  int         bad;
  logic [W+3:0] exp_q[$];

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: {N,Z,C,V, result} from plain unsigned/signed arithmetic.
  function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [63:0]  wide_a;
    logic [63:0]  p;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    wide_a = {32'b0, a};
    case (op)
      3'd0: begin
        r = a + b;
        c = (wide_a + {32'b0, b}) > 64'hFFFF_FFFF;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        p = wide_a * {32'b0, b};
        r = p[W-1:0];
      end
      default: r = '0;
    endcase
    return {r[W-1], (r == '0), c, v, r};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  // Driver: present one request at the falling edge
  task automatic drive(input logic s, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.start      = s;
    bus.ALUControl = op;
    bus.a          = a;
    bus.b          = b;
  endtask

  // One single-cycle op with explicit expected values from the test plan
  task automatic single_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef);
    drive(1'b1, op, a, b);
    @(negedge clk);
    drive(1'b0, 3'd0, '0, '0);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_res"}, 64'(bus.Result), 64'(er));
    check({tag, "_flags"}, 64'(bus.ALUFlags), 64'(ef));
    check({tag, "_model"}, 64'({bus.ALUFlags, bus.Result}), 64'(model(op, a, b)));
    @(negedge clk);
    check({tag, "_done_low"}, 64'(bus.done), 64'd0);
  endtask

  task automatic sb_sample(input string tag);
    logic [W+3:0] e;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check({tag, "_spurious_done"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_result"}, 64'({bus.ALUFlags, bus.Result}), 64'(e));
      end
    end
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         seen_done;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(1'b0, 3'd0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_res", 64'(bus.Result), 64'd0);
    check("rst_flags", 64'(bus.ALUFlags), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.ready), 64'd1);

    single_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);

    // Back-to-back SUBs: done on two consecutive cycles
    drive(1'b1, OP_SUB, 32'd5, 32'd5);
    @(negedge clk);
    check("sub_eq_done", 64'(bus.done), 64'd1);
    check("sub_eq_res", 64'(bus.Result), 64'd0);
    check("sub_eq_flags", 64'(bus.ALUFlags), 64'b0110);
    check("sub_eq_ready", 64'(bus.ready), 64'd1);
    drive(1'b1, OP_SUB, 32'd3, 32'd5);
    @(negedge clk);
    drive(1'b0, 3'd0, '0, '0);
    check("sub_brw_done", 64'(bus.done), 64'd1);
    check("sub_brw_res", 64'(bus.Result), 64'hFFFF_FFFE);
    check("sub_brw_flags", 64'(bus.ALUFlags), 64'b1000);
    @(negedge clk);
    check("sub_done_low", 64'(bus.done), 64'd0);

    single_op("and", OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 4'b0100);
    single_op("eor", OP_EOR, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 4'b1000);
    single_op("rsvd111", 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'b0100);
    single_op("rsvd110", 3'b110, 32'h1234_5678, 32'h1, 32'h0, 4'b0100);

    // MUL: ready low for WIDTH cycles, ADD pulses and operand changes ignored
    drive(1'b1, OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("mul_busy_ready", 64'(bus.ready), 64'd0);
      check("mul_busy_done", 64'(bus.done), 64'd0);
      check("mul_hold_res", 64'(bus.Result), 64'h0);
      if (k == 0) check("mul_state", 64'(dbg_state), 64'(MULT));
      drive(1'($urandom_range(0, 1)), OP_ADD, $urandom, $urandom);
    end
    @(negedge clk);
    drive(1'b0, 3'd0, '0, '0);
    check("mul_done", 64'(bus.done), 64'd1);
    check("mul_res", 64'(bus.Result), 64'hFFFF_FFFF);
    check("mul_flags", 64'(bus.ALUFlags), 64'b1000);
    check("mul_ready", 64'(bus.ready), 64'd1);
    @(negedge clk);
    check("mul_done_low", 64'(bus.done), 64'd0);
    check("mul_ignored_add", 64'(bus.Result), 64'hFFFF_FFFF);

    // Reset during MUL aborts it with no done pulse
    drive(1'b1, OP_MUL, 32'd7, 32'd6);
    @(negedge clk);
    drive(1'b0, 3'd0, '0, '0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_res", 64'(bus.Result), 64'd0);
    check("abort_flags", 64'(bus.ALUFlags), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd1);
    seen_done = 1'b0;
    repeat (W + 8) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      sb_sample("rnd");
      if (bus.ready) begin
        if ($urandom_range(0, 3) != 0) begin
          op = 3'($urandom_range(0, 7));
          ra = rnd_operand();
          rb = rnd_operand();
          drive(1'b1, op, ra, rb);
          exp_q.push_back(model(op, ra, rb));
        end else begin
          drive(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        end
      end else begin
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
    end
    drive(1'b0, 3'd0, '0, '0);
    for (int cyc = 0; cyc < W + 4; cyc++) begin
      @(negedge clk);
      sb_sample("drain");
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
